// File: rtl/pmul_feeder_pkg.sv
// Shared definitions for the partial-sum multiplier feeder: FSM encoding,
// tap count and the per-tap skew rule.
package pmul_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_FILL,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int NUM_TAPS     = 3;
   localparam int DRAIN_CYCLES = 2;

   // Tap k sees its pixel k cycles after tap 0, matching the chain latency.
   function automatic int tap_depth(input int k);
      return k;
   endfunction

endpackage

// File: rtl/pmul_feeder_skew_reg.sv
// WIDTH x DEPTH delay line with a holding output register: the output only
// changes when a valid word reaches the end of the line.
module pmul_feeder_skew_reg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0]            vld_pipe_q, vld_pipe_d;
   logic [DEPTH-1:0][WIDTH-1:0] dat_pipe_q, dat_pipe_d;
   logic [WIDTH-1:0]            out_q, out_d;

   always_comb begin
      vld_pipe_d[0] = in_vld;
      dat_pipe_d[0] = in_data;
      for (int k = 1; k < DEPTH; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
         dat_pipe_d[k] = dat_pipe_q[k-1];
      end
      out_d = vld_pipe_q[DEPTH-1] ? dat_pipe_q[DEPTH-1] : out_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
         out_q      <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
         out_q      <= out_d;
      end
   end

   assign out_data = out_q;

endmodule

// File: rtl/pmul_feeder.sv
// Feeds the 3-tap partial-sum multiplier chain: loads weights, then turns a
// raster pixel stream into one skewed launch per in-row 3-pixel window.
module pmul_feeder
   import pmul_feeder_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int ROW_LEN  = 8,
   parameter int NUM_ROWS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] w_data,
   input  logic             w_valid,
   output logic             w_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_weight0,
   output logic [WIDTH-1:0] out_weight1,
   output logic [WIDTH-1:0] out_weight2,
   output logic             out_update,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(ROW_LEN);
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(ROW_LEN - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);

   state_e                         state_q, state_d;
   logic [CW-1:0]                  col_q, col_d;
   logic [RW-1:0]                  row_q, row_d;
   logic [1:0]                     widx_q, widx_d;
   logic                           drain_q, drain_d;
   logic [WIDTH-1:0]               win0_q, win0_d;   // x[i-1]
   logic [WIDTH-1:0]               win1_q, win1_d;   // x[i-2]
   logic [NUM_TAPS-1:0][WIDTH-1:0] wgt_q, wgt_d;
   logic [WIDTH-1:0]               data0_q, data0_d;
   logic                           upd_q, upd_d;
   logic                           launch;
   logic                           s_hs, w_hs;

   logic [NUM_TAPS-1:1][WIDTH-1:0] tap_in;
   logic [NUM_TAPS-1:0][WIDTH-1:0] tap_out;

   assign w_ready = (state_q == ST_LOAD_W);
   assign s_ready = (state_q == ST_FILL) || (state_q == ST_RUN);
   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign s_hs    = s_valid & s_ready;
   assign w_hs    = w_valid & w_ready;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      widx_d  = widx_q;
      drain_d = drain_q;
      win0_d  = win0_q;
      win1_d  = win1_q;
      wgt_d   = wgt_q;
      data0_d = data0_q;
      upd_d   = 1'b0;
      launch  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD_W;
               widx_d  = '0;
            end
         end
         ST_LOAD_W: begin
            if (w_hs) begin
               for (int k = 0; k < NUM_TAPS; k++)
                  if (widx_q == 2'(k)) wgt_d[k] = w_data;
               if (widx_q == 2'(NUM_TAPS - 1)) begin
                  widx_d  = '0;
                  col_d   = '0;
                  row_d   = '0;
                  state_d = ST_FILL;
               end else begin
                  widx_d = widx_q + 2'd1;
               end
            end
         end
         ST_FILL: begin
            if (s_hs) begin
               win1_d = win0_q;
               win0_d = s_data;
               col_d  = col_q + 1'b1;
               if (col_q == CW'(1)) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (s_hs) begin
               win1_d  = win0_q;
               win0_d  = s_data;
               launch  = 1'b1;
               upd_d   = 1'b1;
               data0_d = win1_q;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     state_d = ST_DRAIN;
                     drain_d = 1'b0;
                  end else begin
                     row_d   = row_q + 1'b1;
                     state_d = ST_FILL;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            // Two cycles so the final tap-2 write lands before done.
            if (drain_q) begin
               drain_d = 1'b0;
               state_d = ST_DONE;
            end else begin
               drain_d = 1'b1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         widx_q  <= '0;
         drain_q <= 1'b0;
         win0_q  <= '0;
         win1_q  <= '0;
         wgt_q   <= '0;
         data0_q <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         widx_q  <= widx_d;
         drain_q <= drain_d;
         win0_q  <= win0_d;
         win1_q  <= win1_d;
         wgt_q   <= wgt_d;
         data0_q <= data0_d;
         upd_q   <= upd_d;
      end
   end

   assign tap_in[1]  = win0_q;
   assign tap_in[2]  = s_data;
   assign tap_out[0] = data0_q;

   for (genvar k = 1; k < NUM_TAPS; k++) begin : g_tap
      pmul_feeder_skew_reg #(
         .WIDTH (WIDTH),
         .DEPTH (tap_depth(k))
      ) u_skew (
         .clk      (clk),
         .rst      (rst),
         .in_vld   (launch),
         .in_data  (tap_in[k]),
         .out_data (tap_out[k])
      );
   end

   assign out_data0   = tap_out[0];
   assign out_data1   = tap_out[1];
   assign out_data2   = tap_out[2];
   assign out_weight0 = wgt_q[0];
   assign out_weight1 = wgt_q[1];
   assign out_weight2 = wgt_q[2];
   assign out_update  = upd_q;

endmodule

// File: tb/tb_pmul_feeder.sv
// Bench for pmul_feeder: directed and random frames, windows reassembled
// from the skewed taps and compared with windows cut from the pixel list.
module tb_pmul_feeder;

   localparam int W  = 8;
   localparam int RL = 5;
   localparam int NR = 2;
   localparam int HN = 4096;

   logic         clk = 1'b0;
   logic         rst, start, w_valid, s_valid;
   logic [W-1:0] w_data, s_data;
   logic         w_ready, s_ready, out_update, busy, done;
   logic [W-1:0] out_data0, out_data1, out_data2;
   logic [W-1:0] out_weight0, out_weight1, out_weight2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic         upd_h[HN], hs_h[HN], done_h[HN];
   logic [W-1:0] d0_h[HN], d1_h[HN], d2_h[HN];

   logic [W-1:0] pix[$];
   int           stl[$];
   logic [23:0]  win_q[$];

   pmul_feeder #(.WIDTH(W), .ROW_LEN(RL), .NUM_ROWS(NR)) dut (
      .clk(clk), .rst(rst), .start(start),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
      .out_weight0(out_weight0), .out_weight1(out_weight1), .out_weight2(out_weight2),
      .out_update(out_update), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Per-cycle record, sampled mid-cycle.
   always @(negedge clk) begin
      if (cyc < HN) begin
         upd_h[cyc]  <= out_update;
         hs_h[cyc]   <= s_valid && s_ready;
         done_h[cyc] <= done;
         d0_h[cyc]   <= out_data0;
         d1_h[cyc]   <= out_data1;
         d2_h[cyc]   <= out_data2;
         cyc         <= cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {27'd0, busy, done, w_ready, s_ready, out_update}, 32'd0);
      chk({tag, "_data"}, {8'd0, out_data0, out_data1, out_data2}, 32'd0);
      chk({tag, "_wgt"}, {8'd0, out_weight0, out_weight1, out_weight2}, 32'd0);
   endtask

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      logic [W-1:0] wv[3];
      wv[0] = a; wv[1] = b; wv[2] = c;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("load_wready", {31'd0, w_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         w_valid = 1'b1;
         w_data  = wv[i];
         for (int g = 0; g < 20 && !w_ready; g++) step();
         if (!w_ready) chk("w_ready_timeout", {31'd0, w_ready}, 32'd1);
         step();
         w_valid = 1'b0;
         if (i == 0) step();
      end
      chk("load_fill_rdy", {30'd0, w_ready, s_ready}, 32'd1);
      chk("load_wgt", {8'd0, out_weight0, out_weight1, out_weight2}, {8'd0, a, b, c});
   endtask

   task automatic send(input logic [W-1:0] p, input int stall);
      if (stall > 0) begin
         s_valid = 1'b0;
         step(stall);
      end
      s_valid = 1'b1;
      s_data  = p;
      for (int g = 0; g < 20 && !s_ready; g++) step();
      if (!s_ready) chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
      step();
      s_valid = 1'b0;
   endtask

   // Streams pix/stl as one frame and checks windows, stalls and done timing.
   task automatic frame(input string tag, input bit consec);
      int fs, last_hs, done_c, ndone, stray;
      int updc[$];
      logic [23:0] expw[$];
      fs = cyc; last_hs = 0; done_c = 0; ndone = 0; stray = 0;
      win_q.delete();
      for (int i = 0; i < pix.size(); i++) send(pix[i], stl[i]);
      for (int g = 0; g < 20 && !done; g++) step();
      if (!done) chk({tag, "_done_timeout"}, {31'd0, done}, 32'd1);
      step(4);
      for (int k = fs; k < cyc; k++) begin
         if (hs_h[k]) last_hs = k;
         if (done_h[k]) begin ndone++; done_c = k; end
         if (upd_h[k] && k + 2 < cyc) begin
            win_q.push_back({d0_h[k], d1_h[k+1], d2_h[k+2]});
            updc.push_back(k);
            if (!hs_h[k-1]) stray++;
         end
      end
      for (int r = 0; r < NR; r++)
         for (int j = 0; j + 2 < RL; j++)
            expw.push_back({pix[r*RL+j], pix[r*RL+j+1], pix[r*RL+j+2]});
      chk({tag, "_nwin"}, win_q.size(), expw.size());
      for (int i = 0; i < expw.size() && i < win_q.size(); i++)
         chk($sformatf("%s_win%0d", tag, i), {8'd0, win_q[i]}, {8'd0, expw[i]});
      chk({tag, "_stray_upd"}, stray, 0);
      chk({tag, "_ndone"}, ndone, 1);
      chk({tag, "_done_lat"}, done_c - last_hs, 3);
      if (consec && updc.size() >= 3) chk({tag, "_consec"}, updc[2] - updc[0], 2);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic rand_frame();
      pix.delete(); stl.delete();
      for (int i = 0; i < RL*NR; i++) begin
         pix.push_back(W'($urandom));
         stl.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
   endtask

   initial begin
      int p, rc, nd;
      logic [W-1:0] ra, rb, rcw;
      start = 0; w_valid = 0; s_valid = 0; w_data = '0; s_data = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      step(3);
      chk_zero("rst_hold");
      rst = 1'b1;
      step();
      chk_zero("rst_rel");

      // Directed frame with a 3-cycle stall mid row 2.
      load(8'd1, 8'd2, 8'd3);
      pix.delete(); stl.delete();
      for (int i = 0; i < RL*NR; i++) begin
         pix.push_back(W'(10 * (i + 1)));
         stl.push_back(i == 8 ? 3 : 0);
      end
      frame("dir", 1'b1);
      for (int i = 0; i < 3 && i < win_q.size(); i++) begin
         p = (int'(out_weight0) * int'(win_q[i][23:16]) + int'(out_weight1) * int'(win_q[i][15:8])
              + int'(out_weight2) * int'(win_q[i][7:0])) % 256;
         chk($sformatf("psum%0d", i), p, (i == 0) ? 140 : (i == 1) ? 200 : 4);
      end
      chk("wgt_retain", {8'd0, out_weight0, out_weight1, out_weight2}, {8'd0, 8'd1, 8'd2, 8'd3});

      // Random weights and pixels with random stalls.
      ra = W'($urandom); rb = W'($urandom); rcw = W'($urandom);
      load(ra, rb, rcw);
      rand_frame();
      frame("rnd1", 1'b0);

      // Reset in RUN: clears at once and never produces done.
      load(8'd7, 8'd8, 8'd9);
      for (int i = 0; i < 4; i++) send(W'(i + 33), 0);
      rc = cyc;
      rst = 1'b0;
      #1;
      chk_zero("rst_mid");
      step(2);
      rst = 1'b1;
      step(8);
      nd = 0;
      for (int k = rc; k < cyc; k++) if (done_h[k]) nd++;
      chk("rst_mid_nodone", nd, 0);

      ra = W'($urandom); rb = W'($urandom); rcw = W'($urandom);
      load(ra, rb, rcw);
      rand_frame();
      frame("rnd2", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
